control_frame_buffer_write_only: RTL and testbench

//   Write-side controller for the frame buffer, counterpart of the read-side controller.

---
 rtl/fb_ctrl_pkg.sv | 20 ++
 rtl/control_frame_buffer_write_only_if.sv | 37 +++
 rtl/fb_strobe_counter.sv | 36 +++
 rtl/control_frame_buffer_write_only.sv | 170 +++++++++++++++++
 tb/tb_control_frame_buffer_write_only.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/fb_ctrl_pkg.sv
// fb_ctrl_pkg: definitions shared by the frame-buffer read-side and write-side
// controllers. These are the FSM state encodings, the default bus widths, and a
// helper that sizes a period-N strobe counter.
package fb_ctrl_pkg;

  localparam int FB_ADDR_WIDTH = 32;
  localparam int FB_DATA_WIDTH = 16;

  typedef enum logic [0:0] {
    ST_WAIT_SOF = 1'b0,
    ST_WRITING  = 1'b1
  } fb_state_t;

  // Bits needed to count 0..period-1. A period of 1 still gets one bit, so
  // the counter register never collapses to zero width.
  function automatic int strobe_cnt_width(input int period);
    return (period > 1) ? $clog2(period) : 1;
  endfunction

endpackage

// File: rtl/control_frame_buffer_write_only_if.sv
// control_frame_buffer_write_only_if: capture-FIFO pop side and frame-buffer
// write side of the write controller, bundled into one interface.
// The master modport is the controller. The slave modport is the FIFO and
// frame-buffer environment.
interface control_frame_buffer_write_only_if
  import fb_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = FB_ADDR_WIDTH,
  parameter int DATA_WIDTH = FB_DATA_WIDTH
) ();

  logic                  fifo_empty_i;
  logic [DATA_WIDTH-1:0] fifo_data_i;
  logic                  fifo_rd_o;
  logic                  wr_o;
  logic [ADDR_WIDTH-1:0] addr_wr_o;
  logic [DATA_WIDTH-1:0] data_wr_o;

  modport master (
    input  fifo_empty_i,
    input  fifo_data_i,
    output fifo_rd_o,
    output wr_o,
    output addr_wr_o,
    output data_wr_o
  );

  modport slave (
    output fifo_empty_i,
    output fifo_data_i,
    input  fifo_rd_o,
    input  wr_o,
    input  addr_wr_o,
    input  data_wr_o
  );

endinterface

// File: rtl/fb_strobe_counter.sv
// fb_strobe_counter: period-N enable generator. The enable output is high
// whenever the count is zero.
// - hold freezes the count.
// - clear forces the count back to zero, so the next enable comes at once.
// The read-side controller reuses this block.
module fb_strobe_counter
  import fb_ctrl_pkg::*;
#(
  parameter int PERIOD = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic hold,
  output logic enable
);

  localparam int CW = strobe_cnt_width(PERIOD);
  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

  logic [CW-1:0] cnt;

  // Count 0..PERIOD-1 and wrap. Clear wins over hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (!hold) begin
      cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
    end
  end

  assign enable = (cnt == '0);

endmodule

// File: rtl/control_frame_buffer_write_only.sv
// control_frame_buffer_write_only: write-side frame-buffer controller.
// It pops pixels from the camera capture FIFO and writes them into the frame
// buffer, starting each frame at a start-of-frame pulse.
// Optional feature macro: FB_WR_SYNC_ERR_CNT_EN. When defined, it adds
// sync_err_cnt_o, a saturating count of early and late start-of-frame events.
module control_frame_buffer_write_only
  import fb_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH          = FB_ADDR_WIDTH,
  parameter int DATA_WIDTH          = FB_DATA_WIDTH,
  parameter int FIFO_DEPTH_WIDTH    = 9,
  parameter int WRITE_STROBE_PERIOD = 1
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [15:0]          resolution_width_i,
  input  logic [15:0]          resolution_depth_i,
  input  logic                 frame_start_i,
  control_frame_buffer_write_only_if.master fb_bus,
  output logic                 page_written_once_o,
  output logic                 frame_done_o,
  output logic                 sync_err_o
`ifdef FB_WR_SYNC_ERR_CNT_EN
  ,
  output logic [15:0]          sync_err_cnt_o
`endif
);

  if (WRITE_STROBE_PERIOD < 1 || FIFO_DEPTH_WIDTH < 1) begin : g_param_check
    $error("control_frame_buffer_write_only: WRITE_STROBE_PERIOD and FIFO_DEPTH_WIDTH must be >= 1");
  end

  fb_state_t             state, state_next;
  logic [ADDR_WIDTH-1:0] pointer, pointer_next;
  logic [ADDR_WIDTH-1:0] frame_pixels, total_pixel, tag_addr;
  logic                  frame_empty, strobe_en, pop, pop_write, tag_last;
  logic                  sync_err_next;
  logic                  s1_valid, s1_last;
  logic [ADDR_WIDTH-1:0] s1_addr;

  assign frame_pixels = ADDR_WIDTH'(resolution_width_i) * ADDR_WIDTH'(resolution_depth_i);
  assign total_pixel  = frame_pixels - ADDR_WIDTH'(1);
  assign frame_empty  = (frame_pixels == '0);
  assign tag_last     = (tag_addr == total_pixel);
  assign fb_bus.fifo_rd_o = pop;

  // The strobe phase runs only while the FIFO has data. It is parked at zero
  // outside a frame, so the first pixel of every frame pops immediately.
  fb_strobe_counter #(
    .PERIOD (WRITE_STROBE_PERIOD)
  ) u_strobe (
    .clk    (clk_i),
    .rst    (reset_i),
    .clear  (state == ST_WAIT_SOF),
    .hold   (fb_bus.fifo_empty_i),
    .enable (strobe_en)
  );

  // Next state, pointer update, pop decision and address tag for this cycle.
  always_comb begin
    state_next    = state;
    pointer_next  = pointer;
    tag_addr      = pointer;
    pop           = 1'b0;
    pop_write     = 1'b0;
    sync_err_next = 1'b0;
    case (state)
      ST_WAIT_SOF: begin
        pop = !fb_bus.fifo_empty_i;
        if (frame_start_i && !frame_empty) begin
          pointer_next = '0;
          state_next   = ST_WRITING;
        end
      end
      ST_WRITING: begin
        if (frame_start_i) begin
          tag_addr      = '0;
          sync_err_next = (pointer != '0);
        end
        pointer_next = tag_addr;
        if (!fb_bus.fifo_empty_i && strobe_en) begin
          pop       = 1'b1;
          pop_write = 1'b1;
          if (tag_last) begin
            pointer_next = '0;
            state_next   = ST_WAIT_SOF;
          end else begin
            pointer_next = tag_addr + ADDR_WIDTH'(1);
          end
        end
      end
      default: state_next = ST_WAIT_SOF;
    endcase
  end

  // State register, pixel pointer and the registered sync-error pulse.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state      <= ST_WAIT_SOF;
      pointer    <= '0;
      sync_err_o <= 1'b0;
    end else begin
      state      <= state_next;
      pointer    <= pointer_next;
      sync_err_o <= sync_err_next;
    end
  end

  // First pipeline stage: remember which address was popped while the FIFO
  // produces the data one cycle later.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      s1_valid <= 1'b0;
      s1_addr  <= '0;
      s1_last  <= 1'b0;
    end else begin
      s1_valid <= pop_write;
      s1_addr  <= tag_addr;
      s1_last  <= pop_write & tag_last;
    end
  end

  // Second stage: register the write. The address holds between writes, and
  // the page flag is sticky once a full frame has landed.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      fb_bus.wr_o         <= 1'b0;
      fb_bus.addr_wr_o    <= '0;
      fb_bus.data_wr_o    <= '0;
      frame_done_o        <= 1'b0;
      page_written_once_o <= 1'b0;
    end else begin
      fb_bus.wr_o  <= s1_valid;
      frame_done_o <= s1_valid & s1_last;
      if (s1_valid) begin
        fb_bus.addr_wr_o <= s1_addr;
        fb_bus.data_wr_o <= fb_bus.fifo_data_i;
      end
      if (s1_valid && s1_last) begin
        page_written_once_o <= 1'b1;
      end
    end
  end

`ifdef FB_WR_SYNC_ERR_CNT_EN
  logic late_armed, late_hit;

  // A completed frame arms the late-SOF detector. The first pixel that shows
  // up before the next start-of-frame counts as one late event.
  assign late_hit = (state == ST_WAIT_SOF) && late_armed && !fb_bus.fifo_empty_i && !frame_start_i;

  // Late-SOF arming and the saturating event counter.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      late_armed     <= 1'b0;
      sync_err_cnt_o <= '0;
    end else begin
      if (state == ST_WRITING && state_next == ST_WAIT_SOF) begin
        late_armed <= 1'b1;
      end else if (frame_start_i || late_hit) begin
        late_armed <= 1'b0;
      end
      if ((sync_err_next || late_hit) && sync_err_cnt_o != 16'hFFFF) begin
        sync_err_cnt_o <= sync_err_cnt_o + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_control_frame_buffer_write_only.sv
// tb_control_frame_buffer_write_only: two controllers, one popping every
// cycle and one popping every 4th cycle, share the frame controls.
// Each controller has its own capture FIFO. A frame-level reference model
// predicts the pops and the write stream of each controller.
`timescale 1ns/1ps
module tb_control_frame_buffer_write_only;
  import fb_ctrl_pkg::*;

  localparam int AW = 32;
  localparam int DW = 16;

  typedef struct {
    int          due;
    int          addr;
    logic [15:0] data;
    bit          last;
  } wr_ev_t;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [15:0] res_width, res_depth;
  logic        frame_start_i;
  logic [1:0]  page_w, frame_done, sync_err;
`ifdef FB_WR_SYNC_ERR_CNT_EN
  logic [15:0] err_cnt0, err_cnt1;
`endif

  control_frame_buffer_write_only_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus0 ();
  control_frame_buffer_write_only_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus1 ();

  control_frame_buffer_write_only #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH_WIDTH(9), .WRITE_STROBE_PERIOD(1)
  ) dut0 (
    .clk_i(clk_i), .reset_i(reset_i),
    .resolution_width_i(res_width), .resolution_depth_i(res_depth),
    .frame_start_i(frame_start_i), .fb_bus(bus0.master),
    .page_written_once_o(page_w[0]), .frame_done_o(frame_done[0]), .sync_err_o(sync_err[0])
`ifdef FB_WR_SYNC_ERR_CNT_EN
    , .sync_err_cnt_o(err_cnt0)
`endif
  );

  control_frame_buffer_write_only #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH_WIDTH(9), .WRITE_STROBE_PERIOD(4)
  ) dut1 (
    .clk_i(clk_i), .reset_i(reset_i),
    .resolution_width_i(res_width), .resolution_depth_i(res_depth),
    .frame_start_i(frame_start_i), .fb_bus(bus1.master),
    .page_written_once_o(page_w[1]), .frame_done_o(frame_done[1]), .sync_err_o(sync_err[1])
`ifdef FB_WR_SYNC_ERR_CNT_EN
    , .sync_err_cnt_o(err_cnt1)
`endif
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  always #5 clk_i = ~clk_i;

  int          num_checks = 0;
  int          num_fails  = 0;
  int          cycle      = 0;
  int          period_of [2] = '{1, 4};
  bit          in_frame  [2];
  int          ptr       [2];
  int          phase     [2];
  int          exp_addr  [2];
  bit          exp_page  [2];
  bit          exp_err   [2];
  logic [15:0] next_data [2];
  wr_ev_t      pend      [2][$];

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    num_checks++;
    if (got !== exp) begin
      num_fails++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", tag, cycle, got, exp);
    end
  endtask

  task automatic modelReset();
    for (int k = 0; k < 2; k++) begin
      in_frame[k] = 1'b0;
      ptr[k]      = 0;
      phase[k]    = 0;
      exp_addr[k] = 0;
      exp_page[k] = 1'b0;
      exp_err[k]  = 1'b0;
      pend[k].delete();
    end
  endtask

  // One clock cycle: drive the inputs, compare both controllers against the
  // model, then advance the model across the rising edge.
  task automatic applyStimulus(input bit rst, input bit sof, input bit [1:0] empty_in);
    int          size;
    bit          pred [2];
    bit          o_rd, o_wr, o_done, o_page, o_err, exp_wr, exp_done;
    logic [31:0] o_addr;
    logic [15:0] o_data;
    wr_ev_t      ev;
    reset_i             = rst;
    frame_start_i       = sof;
    bus0.fifo_empty_i   = empty_in[0];
    bus1.fifo_empty_i   = empty_in[1];
    bus0.fifo_data_i    = next_data[0];
    bus1.fifo_data_i    = next_data[1];
    if (rst) modelReset();
    #1;
    size = int'(res_width) * int'(res_depth);
    for (int k = 0; k < 2; k++) begin
      pred[k] = in_frame[k] ? (!empty_in[k] && phase[k] == 0) : !empty_in[k];
      if (k == 0) begin
        o_rd = bus0.fifo_rd_o; o_wr = bus0.wr_o; o_addr = bus0.addr_wr_o; o_data = bus0.data_wr_o;
      end else begin
        o_rd = bus1.fifo_rd_o; o_wr = bus1.wr_o; o_addr = bus1.addr_wr_o; o_data = bus1.data_wr_o;
      end
      o_done = frame_done[k]; o_page = page_w[k]; o_err = sync_err[k];
      exp_wr = 1'b0; exp_done = 1'b0; ev = '{0, 0, 16'h0, 1'b0};
      if (pend[k].size() > 0 && pend[k][0].due == cycle) begin
        ev          = pend[k].pop_front();
        exp_wr      = 1'b1;
        exp_done    = ev.last;
        exp_addr[k] = ev.addr;
        if (ev.last) exp_page[k] = 1'b1;
      end
      checkOutput($sformatf("d%0d.fifo_rd", k), 64'(o_rd), 64'(pred[k]));
      checkOutput($sformatf("d%0d.wr", k), 64'(o_wr), 64'(exp_wr));
      checkOutput($sformatf("d%0d.addr", k), 64'(o_addr), 64'(exp_addr[k]));
      if (exp_wr) checkOutput($sformatf("d%0d.data", k), 64'(o_data), 64'(ev.data));
      checkOutput($sformatf("d%0d.frame_done", k), 64'(o_done), 64'(exp_done));
      checkOutput($sformatf("d%0d.page_written", k), 64'(o_page), 64'(exp_page[k]));
      checkOutput($sformatf("d%0d.sync_err", k), 64'(o_err), 64'(exp_err[k]));
    end
    for (int k = 0; k < 2; k++) begin
      logic [15:0] presented;
      presented    = 16'($urandom);
      next_data[k] = presented;
      if (rst) continue;
      exp_err[k] = 1'b0;
      if (!in_frame[k]) begin
        if (sof && size != 0) begin
          in_frame[k] = 1'b1;
          ptr[k]      = 0;
          phase[k]    = 0;
        end
      end else begin
        if (sof) begin
          exp_err[k] = (ptr[k] != 0);
          ptr[k]     = 0;
        end
        if (pred[k]) begin
          pend[k].push_back('{cycle + 2, ptr[k], presented, ptr[k] == size - 1});
          if (ptr[k] == size - 1) begin
            in_frame[k] = 1'b0;
            ptr[k]      = 0;
          end else begin
            ptr[k]++;
          end
        end
        if (!empty_in[k]) phase[k] = (phase[k] + 1) % period_of[k];
      end
    end
    @(posedge clk_i);
    cycle++;
    @(negedge clk_i);
  endtask

  // Watchdog so the run always ends even if the stimulus loop stalls.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Scenario sequence: directed frames first, then randomized epochs.
  initial begin
    reset_i = 1'b1; frame_start_i = 1'b0; res_width = 16'd4; res_depth = 16'd2;
    bus0.fifo_empty_i = 1'b1; bus1.fifo_empty_i = 1'b1;
    bus0.fifo_data_i = '0; bus1.fifo_data_i = '0;
    next_data[0] = '0; next_data[1] = '0;
    modelReset();
    @(negedge clk_i);

    // Reset state, then data before any start-of-frame is dropped.
    applyStimulus(1, 0, 2'b11);
    applyStimulus(1, 0, 2'b11);
    repeat (8) applyStimulus(0, 0, 2'($urandom));

    // Early SOF when the fast controller is at pixel 5; the page flag must
    // wait for a full 8-pixel frame.
    applyStimulus(0, 1, 2'b00);
    for (int i = 0; i < 20 && ptr[0] != 5; i++) applyStimulus(0, 0, 2'b00);
    applyStimulus(0, 1, 2'b00);
    repeat (45) applyStimulus(0, 0, 2'b00);

    // Clean 4x2 frame with the FIFO never empty, then drops after frame end.
    applyStimulus(1, 0, 2'b00);
    applyStimulus(0, 1, 2'b00);
    repeat (40) applyStimulus(0, 0, 2'b00);

    // FIFO empty toggling every cycle during a frame.
    applyStimulus(0, 1, 2'b00);
    for (int i = 0; i < 80; i++) applyStimulus(0, 0, (i % 2) ? 2'b11 : 2'b00);

    // Reset at pixel 3 with a pop in flight, then restart at address 0.
    applyStimulus(0, 1, 2'b00);
    for (int i = 0; i < 20 && ptr[0] != 3; i++) applyStimulus(0, 0, 2'b00);
    applyStimulus(1, 0, 2'b00);
    repeat (3) applyStimulus(0, 0, 2'b00);
    applyStimulus(0, 1, 2'b00);
    repeat (40) applyStimulus(0, 0, 2'b00);

    // Randomized epochs. Each one picks a resolution under reset; a zero
    // width gives an empty frame.
    for (int e = 0; e < 6; e++) begin
      res_width = 16'($urandom_range(0, 5));
      res_depth = 16'($urandom_range(1, 3));
      applyStimulus(1, 0, 2'b11);
      for (int i = 0; i < 250; i++) begin
        applyStimulus(0, ($urandom_range(0, 29) == 0), {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)});
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", num_checks, num_fails);
    $finish;
  end

endmodule
